// File: rtl/player_pkg.sv
// Shared types and constants for the player physics slice.
package player_pkg;

  localparam int unsigned kPosW         = 10;
  localparam int unsigned kVelW         = 6;
  localparam int unsigned kGrassTop     = 384;
  localparam int unsigned kPlayerWidth  = 16;
  localparam int unsigned kPlayerHeight = 16;

  typedef enum logic [1:0] {
    GROUND  = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2
  } player_state_t;

endpackage

// File: rtl/player_motion_btn_sync.sv
// Two-flop button synchronizer with an optional registered rising-edge pulse.
module btn_sync #(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;

  // Two-stage synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
    end
  end

  assign o_level = r_sync;

  generate
    if (EDGE_EN) begin : g_edge
      logic r_sync_d;
      logic r_rise;
      // Registered edge pulse, one cycle after the synchronized level rises.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync_d <= 1'b0;
          r_rise   <= 1'b0;
        end else begin
          r_sync_d <= r_sync;
          r_rise   <= r_sync & ~r_sync_d;
        end
      end
      assign o_rise = r_rise;
    end else begin : g_no_edge
      assign o_rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/player_motion.sv
// Per-frame player physics: horizontal walk with clamping, jump/gravity FSM.
// Optional auto-walk when no direction is held: PLAYER_MOTION_AUTOWALK_EN.
module player_motion
  import player_pkg::*;
#(
  parameter int unsigned RANGE_X     = 624,
  parameter int unsigned RANGE_Y     = 368,
  parameter int unsigned JUMP_VEL    = 8,
  parameter int unsigned MAX_FALL    = 15,
  parameter int unsigned GRAV_PERIOD = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_end,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_jump,
  output logic [kPosW-1:0] px,
  output logic [kPosW-1:0] py,
  output logic [1:0]       state,
  output logic             on_ground
);

  localparam logic [kPosW:0]   kRangeX  = (kPosW+1)'(RANGE_X);
  localparam logic [kPosW:0]   kRangeY  = (kPosW+1)'(RANGE_Y);
  localparam logic [kVelW-1:0] kJumpVel = kVelW'(JUMP_VEL);
  localparam logic [kVelW-1:0] kMaxFall = kVelW'(MAX_FALL);
  localparam logic [3:0]       kGravLast = 4'(GRAV_PERIOD - 1);

  logic w_left, w_right, w_jump_rise;
  logic w_unused_left_rise, w_unused_right_rise, w_unused_jump_level;

  btn_sync #(.EDGE_EN(1'b0)) u_sync_left (
    .clk(clk), .reset(reset), .i_btn(btn_left),
    .o_level(w_left), .o_rise(w_unused_left_rise)
  );
  btn_sync #(.EDGE_EN(1'b0)) u_sync_right (
    .clk(clk), .reset(reset), .i_btn(btn_right),
    .o_level(w_right), .o_rise(w_unused_right_rise)
  );
  btn_sync #(.EDGE_EN(1'b1)) u_sync_jump (
    .clk(clk), .reset(reset), .i_btn(btn_jump),
    .o_level(w_unused_jump_level), .o_rise(w_jump_rise)
  );

  player_state_t    r_state, w_state_nx;
  logic [kPosW-1:0] r_px, r_py, w_px_nx, w_py_nx;
  logic [kVelW-1:0] r_vy, w_vy_nx;
  logic [3:0]       r_grav_cnt, w_grav_nx;
  logic             r_jump_req, r_on_ground;
  logic             w_req, w_grav_step, w_go_left, w_go_right;
  logic [kPosW:0]   w_vy_ext, w_py_sum, w_px_inc;
`ifdef PLAYER_MOTION_AUTOWALK_EN
  logic             r_dx, w_dx_nx;
`endif

  // Walk direction decode; auto-walk bounces off the edges by flipping dx.
  always_comb begin
    w_go_left  = w_left & ~w_right;
    w_go_right = w_right & ~w_left;
`ifdef PLAYER_MOTION_AUTOWALK_EN
    w_dx_nx = r_dx;
    if (w_go_left) begin
      w_dx_nx = 1'b0;
    end else if (w_go_right) begin
      w_dx_nx = 1'b1;
    end else if (!w_left && !w_right) begin
      if ({1'b0, r_px} == kRangeX)  w_dx_nx = 1'b0;
      else if (r_px == '0)          w_dx_nx = 1'b1;
      w_go_left  = ~w_dx_nx;
      w_go_right = w_dx_nx;
    end
`endif
  end

  // Horizontal next position with clamping at both screen edges.
  always_comb begin
    w_px_inc = {1'b0, r_px} + 1'b1;
    w_px_nx  = r_px;
    if (w_go_left) begin
      w_px_nx = (r_px == '0) ? '0 : r_px - 1'b1;
    end else if (w_go_right) begin
      w_px_nx = (w_px_inc > kRangeX) ? kRangeX[kPosW-1:0] : w_px_inc[kPosW-1:0];
    end
  end

  // Jump FSM next state and vertical datapath.
  always_comb begin
    w_req       = r_jump_req | w_jump_rise;
    w_grav_step = (r_grav_cnt == kGravLast);
    w_vy_ext    = {{(kPosW+1-kVelW){1'b0}}, r_vy};
    w_py_sum    = {1'b0, r_py} + w_vy_ext;
    w_state_nx  = r_state;
    w_py_nx     = r_py;
    w_vy_nx     = r_vy;
    w_grav_nx   = w_grav_step ? '0 : r_grav_cnt + 1'b1;
    case (r_state)
      GROUND: begin
        if (w_req) begin
          w_vy_nx    = kJumpVel;
          w_grav_nx  = '0;
          w_state_nx = RISING;
        end
      end
      RISING: begin
        if (w_py_sum > kRangeY) begin
          w_py_nx    = kRangeY[kPosW-1:0];
          w_vy_nx    = '0;
          w_state_nx = FALLING;
        end else begin
          w_py_nx = w_py_sum[kPosW-1:0];
          if (w_grav_step) begin
            w_vy_nx = r_vy - 1'b1;
            if (r_vy == kVelW'(1)) w_state_nx = FALLING;
          end
        end
      end
      FALLING: begin
        if ({1'b0, r_py} <= w_vy_ext) begin
          w_py_nx    = '0;
          w_vy_nx    = '0;
          w_state_nx = GROUND;
        end else begin
          w_py_nx = r_py - w_vy_ext[kPosW-1:0];
          if (w_grav_step) w_vy_nx = (r_vy >= kMaxFall) ? kMaxFall : r_vy + 1'b1;
        end
      end
      default: w_state_nx = GROUND;
    endcase
  end

  // State register, advanced only on the frame strobe.
  always_ff @(posedge clk) begin
    if (reset)          r_state <= GROUND;
    else if (frame_end) r_state <= w_state_nx;
  end

  // Position/velocity registers and sticky jump request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_px        <= '0;
      r_py        <= '0;
      r_vy        <= '0;
      r_grav_cnt  <= '0;
      r_jump_req  <= 1'b0;
      r_on_ground <= 1'b1;
`ifdef PLAYER_MOTION_AUTOWALK_EN
      r_dx        <= 1'b1;
`endif
    end else if (frame_end) begin
      r_px        <= w_px_nx;
      r_py        <= w_py_nx;
      r_vy        <= w_vy_nx;
      r_grav_cnt  <= w_grav_nx;
      r_jump_req  <= 1'b0;
      r_on_ground <= (w_state_nx == GROUND);
`ifdef PLAYER_MOTION_AUTOWALK_EN
      r_dx        <= w_dx_nx;
`endif
    end else if (w_jump_rise) begin
      r_jump_req <= 1'b1;
    end
  end

  assign px        = r_px;
  assign py        = r_py;
  assign state     = r_state;
  assign on_ground = r_on_ground;

endmodule

// File: tb/tb_player_motion.sv
// Directed self-checking bench for player_motion (default parameters).
module tb_player_motion;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_end = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_jump = 1'b0;
  logic [9:0] px, py;
  logic [1:0] state;
  logic       on_ground;

  int errors = 0;
  int checks = 0;

  int prof [17] = '{8, 15, 21, 26, 30, 33, 35, 36, 36, 35, 33, 30, 26, 21, 15, 8, 0};

`ifdef PLAYER_MOTION_AUTOWALK_EN
  localparam int kIdlePx  = 5;
  localparam int kStartPx = 2;
`else
  localparam int kIdlePx  = 0;
  localparam int kStartPx = 0;
`endif

  player_motion #(
    .RANGE_X(624), .RANGE_Y(368), .JUMP_VEL(8), .MAX_FALL(15), .GRAV_PERIOD(1)
  ) dut (
    .clk(clk), .reset(reset), .frame_end(frame_end),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .px(px), .py(py), .state(state), .on_ground(on_ground)
  );

  always #5 clk = ~clk;

  task automatic do_frame();
    repeat (3) @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (px !== 10'd0) begin errors++; $display("FAIL reset_px got=%0d exp=0", px); end
    checks++; if (py !== 10'd0) begin errors++; $display("FAIL reset_py got=%0d exp=0", py); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (on_ground !== 1'b1) begin errors++; $display("FAIL reset_on_ground got=%0b exp=1", on_ground); end
    reset = 1'b0;
    repeat (5) do_frame();
    checks++; if (px !== 10'(kIdlePx)) begin errors++; $display("FAIL idle_px got=%0d exp=%0d", px, kIdlePx); end
    checks++; if (py !== 10'd0) begin errors++; $display("FAIL idle_py got=%0d exp=0", py); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_state got=%0d exp=0", state); end
  endtask

  task automatic test_left_clamp();
    btn_left = 1'b1;
    repeat (3) do_frame();
    btn_left = 1'b0;
    checks++; if (px !== 10'(kStartPx)) begin errors++; $display("FAIL left_clamp_px got=%0d exp=%0d", px, kStartPx); end
  endtask

  task automatic test_walk();
    btn_right = 1'b1;
    for (int f = 1; f <= 700; f++) begin
      do_frame();
      if (f == 1) begin
        checks++; if (px !== 10'(kStartPx + 1)) begin errors++; $display("FAIL right_first_px got=%0d exp=%0d", px, kStartPx + 1); end
      end
      if (f == 623 - kStartPx) begin
        checks++; if (px !== 10'd623) begin errors++; $display("FAIL right_pre_clamp_px got=%0d exp=623", px); end
      end
      if (f == 624 - kStartPx) begin
        checks++; if (px !== 10'd624) begin errors++; $display("FAIL right_reach_px got=%0d exp=624", px); end
      end
    end
    checks++; if (px !== 10'd624) begin errors++; $display("FAIL right_hold_px got=%0d exp=624", px); end
    btn_right = 1'b0;
    btn_left  = 1'b1;
    repeat (10) do_frame();
    btn_left  = 1'b0;
    checks++; if (px !== 10'd614) begin errors++; $display("FAIL left_walk_px got=%0d exp=614", px); end
  endtask

  task automatic test_back_to_back();
    btn_right = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (px !== 10'd614) begin errors++; $display("FAIL b2b_stable_px got=%0d exp=614", px); end
    frame_end = 1'b1;
    repeat (3) @(negedge clk);
    frame_end = 1'b0;
    btn_right = 1'b0;
    checks++; if (px !== 10'd617) begin errors++; $display("FAIL b2b_px got=%0d exp=617", px); end
  endtask

  task automatic run_flight(input int inj_a, input int inj_b);
    int exp_state;
    btn_jump = 1'b1;
    repeat (6) @(negedge clk);
    btn_jump = 1'b0;
    do_frame();
    checks++; if (py !== 10'd0) begin errors++; $display("FAIL launch_py got=%0d exp=0", py); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL launch_state got=%0d exp=1", state); end
    checks++; if (on_ground !== 1'b0) begin errors++; $display("FAIL launch_on_ground got=%0b exp=0", on_ground); end
    for (int i = 0; i < 17; i++) begin
      if (i == inj_a || i == inj_b) begin
        btn_jump = 1'b1;
        repeat (5) @(negedge clk);
        btn_jump = 1'b0;
      end
      do_frame();
      exp_state = (i < 7) ? 1 : (i < 16) ? 2 : 0;
      checks++; if (py !== 10'(prof[i])) begin errors++; $display("FAIL flight_py[%0d] got=%0d exp=%0d", i, py, prof[i]); end
      checks++; if (state !== 2'(exp_state)) begin errors++; $display("FAIL flight_state[%0d] got=%0d exp=%0d", i, state, exp_state); end
    end
    checks++; if (on_ground !== 1'b1) begin errors++; $display("FAIL land_on_ground got=%0b exp=1", on_ground); end
    do_frame();
    checks++; if (state !== 2'd0 || py !== 10'd0) begin errors++; $display("FAIL after_land got state=%0d py=%0d exp state=0 py=0", state, py); end
  endtask

  task automatic test_jump();
    run_flight(-1, -1);
  endtask

  task automatic test_jump_airborne();
    run_flight(3, 12);
  endtask

  task automatic test_jump_same_cycle();
    btn_jump = 1'b1;
    repeat (3) @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    btn_jump  = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL same_cycle_state got=%0d exp=1", state); end
    checks++; if (py !== 10'd0) begin errors++; $display("FAIL same_cycle_py got=%0d exp=0", py); end
    repeat (17) do_frame();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL same_cycle_land got=%0d exp=0", state); end
  endtask

  task automatic test_reset_mid_jump();
    btn_jump = 1'b1;
    repeat (6) @(negedge clk);
    btn_jump = 1'b0;
    do_frame();
    repeat (4) do_frame();
    checks++; if (py !== 10'd26 || state !== 2'd1) begin errors++; $display("FAIL pre_reset got py=%0d state=%0d exp py=26 state=1", py, state); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (py !== 10'd0) begin errors++; $display("FAIL mid_reset_py got=%0d exp=0", py); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL mid_reset_state got=%0d exp=0", state); end
    checks++; if (px !== 10'd0) begin errors++; $display("FAIL mid_reset_px got=%0d exp=0", px); end
    checks++; if (on_ground !== 1'b1) begin errors++; $display("FAIL mid_reset_on_ground got=%0b exp=1", on_ground); end
    reset = 1'b0;
    @(negedge clk);
    run_flight(-1, -1);
  endtask

  initial begin
    test_reset();
    test_left_clamp();
    test_walk();
    test_back_to_back();
    test_jump();
    test_jump_airborne();
    test_jump_same_cycle();
    test_reset_mid_jump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
